// File: rtl/acc_hex_display.sv
// -----------------------------------------------------------------------------
// acc_hex_display
//
// Shows the 8-bit accumulator value on a single 7-segment display as two hex
// digits in time: high nibble (dp lit), low nibble (dp dark), then a blank gap.
// The value is snapshotted once per sequence (on the BLANK->HI transition) so
// both digits always come from the same accumulator value.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   ena        enable; low freezes the sequencer and blanks the display
//   acc_value  accumulator value from the ALU stage
//   acc_valid  capture strobe for acc_value (pulse or level)
//   display    {dp, g, f, e, d, c, b, a}, active-high segments
//   digit_hi   high while the high nibble is displayed
// -----------------------------------------------------------------------------
module acc_hex_display #(
  parameter int unsigned DWELL_CYC = 5_000_000,
  parameter int unsigned BLANK_CYC = 2_500_000,
  parameter int unsigned CNT_W     =
    $clog2(((DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC) + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] acc_value,
  input  logic       acc_valid,
  output logic [7:0] display,
  output logic       digit_hi
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_HI,
    ST_LO
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_RLD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_RLD = CNT_W'(BLANK_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       shown_q,   shown_d;

  // Hex digit to segments, bit order {g, f, e, d, c, b, a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shown_d   = shown_q;
    // pending captures independently of ena and sequencer state
    pending_d = acc_valid ? acc_value : pending_q;

    if (ena) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_HI;
            cnt_d   = DWELL_RLD;
            // a capture on the snapshot edge bypasses pending
            shown_d = acc_valid ? acc_value : pending_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HI: begin
          if (cnt_q == '0) begin
            state_d = ST_LO;
            cnt_d   = DWELL_RLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_LO: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_RLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_RLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= BLANK_RLD;
      pending_q <= '0;
      shown_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
    end
  end

  // Outputs decode only registered state and shown; ena gates them so a frozen
  // sequencer leaves the display dark. Reset forces ST_BLANK, hence an
  // immediately dark display.
  always_comb begin
    display  = '0;
    digit_hi = 1'b0;
    if (ena) begin
      case (state_q)
        ST_HI: begin
          display  = {1'b1, hex7(shown_q[7:4])};
          digit_hi = 1'b1;
        end
        ST_LO: begin
          display  = {1'b0, hex7(shown_q[3:0])};
        end
        default: begin
          display  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_hex_display.sv
// -----------------------------------------------------------------------------
// tb_acc_hex_display
//
// Self-checking bench for acc_hex_display with DWELL_CYC=4, BLANK_CYC=2.
// A phase-based reference model (phase 0..9 within one period) predicts the
// {digit_hi, display} value seen after each clock edge; predictions are queued
// when stimulus is driven and compared once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_acc_hex_display;

  localparam int unsigned DW  = 4;
  localparam int unsigned BL  = 2;
  localparam int unsigned PER = 2 * DW + BL;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] acc_value;
  logic       acc_valid;
  logic [7:0] display;
  logic       digit_hi;

  always #5 clk = ~clk;

  acc_hex_display #(
    .DWELL_CYC (DW),
    .BLANK_CYC (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .acc_value (acc_value),
    .acc_valid (acc_valid),
    .display   (display),
    .digit_hi  (digit_hi)
  );

  logic [6:0]  glyph [16];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  int unsigned m_phase;
  logic [7:0]  m_pending;
  logic [7:0]  m_shown;
  logic [8:0]  exp_q [$];

  task automatic check_eq(input string tag, input logic [8:0] obs,
                          input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_pending = '0;
    m_shown   = '0;
  endtask

  function automatic logic [8:0] model_out(input logic en);
    if (!en || m_phase < BL) return '0;
    if (m_phase < BL + DW)   return {1'b1, 1'b1, glyph[m_shown[7:4]]};
    return {1'b0, 1'b0, glyph[m_shown[3:0]]};
  endfunction

  // Drive one cycle of stimulus, predict, clock, compare.
  task automatic step(input logic v, input logic [7:0] val, input logic en,
                      input string tag);
    acc_valid = v;
    acc_value = val;
    ena       = en;
    if (en) begin
      if (m_phase == BL - 1) m_shown = v ? val : m_pending;
      m_phase = (m_phase + 1) % PER;
    end
    if (v) m_pending = val;
    exp_q.push_back(model_out(en));
    @(posedge clk);
    #1;
    check_eq(tag, {digit_hi, display}, exp_q.pop_front());
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, tag);
  endtask

  task automatic run_to(input int unsigned p, input string tag);
    int unsigned guard = 0;
    while (m_phase != p && guard < 2 * PER) begin
      step(1'b0, 8'h00, 1'b1, tag);
      guard++;
    end
    if (m_phase != p) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: phase %0d not reached, at %0d", tag, p, m_phase);
    end
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst       = 1'b1;
    ena       = 1'b1;
    acc_valid = 1'b0;
    acc_value = 8'h00;
    model_reset();

    // Reset state
    #1;
    check_eq("reset_async", {digit_hi, display}, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold", {digit_hi, display}, 9'h000);
    rst = 1'b0;

    // Basic sequence with a single capture of 0x3C
    step(1'b1, 8'h3C, 1'b1, "basic_cap");
    idle(2 * PER, "basic");

    // Tearing guard: capture during HI only reaches the next period
    run_to(0, "tear_sync");
    step(1'b1, 8'h12, 1'b1, "tear_load");
    run_to(BL + 1, "tear_sync2");
    step(1'b1, 8'hAB, 1'b1, "tear_cap");
    idle(2 * PER, "tear");

    // Bypass: capture on the BLANK->HI edge itself
    run_to(BL - 1, "byp_sync");
    step(1'b1, 8'h7E, 1'b1, "bypass");
    idle(PER, "bypass_run");

    // Enable freeze after 2 HI cycles, with a capture while frozen
    run_to(BL + 1, "frz_sync");
    step(1'b0, 8'h00, 1'b0, "freeze");
    step(1'b0, 8'h00, 1'b0, "freeze");
    step(1'b1, 8'h5A, 1'b0, "freeze_cap");
    step(1'b0, 8'h00, 1'b0, "freeze");
    step(1'b0, 8'h00, 1'b0, "freeze");
    idle(PER + 2, "resume");

    // Asynchronous reset mid-LO, discarding a pending value
    run_to(BL + DW + 1, "rst_sync");
    step(1'b1, 8'h99, 1'b1, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", {digit_hi, display}, 9'h000);
    @(posedge clk);
    #1;
    check_eq("rst_held", {digit_hi, display}, 9'h000);
    #2;
    rst = 1'b0;
    model_reset();
    idle(PER + 2, "post_rst");

    // Full decode: 0x01, 0x23, ... 0xEF, one per period
    for (int unsigned k = 0; k < 8; k++) begin
      logic [7:0] v;
      v = 8'((2 * k) * 16 + 2 * k + 1);
      run_to(0, "dec_sync");
      step(1'b1, v, 1'b1, "decode");
    end
    idle(PER, "decode_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/acc_hex_display.md
Name: acc_hex_display

Overview:
- Downstream stage of the 8-bit accumulator ALU; consumes its accumulator value and drives the single on-board 7-segment display.
- Shows the byte as two hex digits in time: high nibble (dp lit), low nibble (dp dark), blank gap, repeat.
- The value is snapshotted once per cycle of the sequence, so the two digits always belong to the same accumulator value.

Parameters:
- DWELL_CYC, 5_000_000: clock cycles each digit is shown; must be >= 1.
- BLANK_CYC, 2_500_000: clock cycles of the blank gap; must be >= 1.
- CNT_W, $clog2(max(DWELL_CYC,BLANK_CYC)+1): dwell counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  design enable; low freezes the sequencer and blanks the display.
- acc_value  input  8  accumulator value from the ALU stage.
- acc_valid  input  1  high in any cycle where acc_value is to be captured; single-cycle or level.
- display  output  8  {dp, g, f, e, d, c, b, a}, active-high; maps directly to uo_out.
- digit_hi  output  1  high while the high nibble is displayed, for bench/debug.

Behaviour:
- Reset (async assert, sync release): state=BLANK, counter=BLANK_CYC-1, pending=0x00, shown=0x00, display=0x00, digit_hi=0.
- Registers:
  - pending[7:0] loads acc_value on every clk edge with acc_valid=1, regardless of ena or state.
  - shown[7:0] is the value on the display.
- State machine, 3 states, advanced only when ena=1:
  - BLANK: display=0x00. When counter==0, go to HI, counter<=DWELL_CYC-1, shown<=pending; else counter-1.
  - HI: display={1, hex(shown[7:4])}, digit_hi=1. When counter==0, go to LO, counter<=DWELL_CYC-1; else counter-1.
  - LO: display={0, hex(shown[3:0])}. When counter==0, go to BLANK, counter<=BLANK_CYC-1; else counter-1.
- Timing:
  - Each state lasts exactly its parameter in cycles; full period = 2*DWELL_CYC+BLANK_CYC.
  - First HI appears BLANK_CYC cycles after reset release.
- Outputs are decoded from registered state and shown only, with no combinational path from acc_value or acc_valid. An outputs change is visible in the cycle after the transition edge.
- Simultaneous events: if acc_valid=1 on the same edge as BLANK->HI, shown takes acc_value directly (bypass pending). pending also updates.
- Captures during HI or LO affect only pending; shown is never changed mid-sequence.
- ena=0:
  - state, counter and shown hold.
  - display=0x00 and digit_hi=0 while ena=0.
  - Sequence resumes from the held state and count when ena returns to 1.
- Hex decode (gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Mid-operation reset:
  - Immediate return to reset values, with display=0x00 asynchronously.
  - A pending value is discarded.
- Counter has no wrap-around condition: it is always reloaded on a transition and never decrements below 0.

Test Plan:
- Run with DWELL_CYC=4, BLANK_CYC=2, ena=1.
- Basic sequence: reset, pulse acc_valid with acc_value=0x3C, no further valid -> display 0x00 for 2 cycles, then 0xCF for 4 cycles with digit_hi=1, then 0x39 for 4 cycles, then 0x00 for 2; repeats with period 10.
- Tearing guard: value 0x12 displayed; during HI, pulse acc_valid with 0xAB -> LO still shows 2 (0x5B); next HI shows A (0xF7); next LO shows b (0x7C).
- Bypass: acc_valid with 0x7E on the exact BLANK->HI edge -> that HI shows 7 (0x87); following LO shows E (0x79).
- Enable freeze: deassert ena after 2 HI cycles for 5 cycles -> display=0x00, digit_hi=0; on re-enable, HI resumes for exactly 2 more cycles.
- Async reset mid-LO: assert rst between clock edges -> display=0x00 immediately. After release, display shows 0x00 for 2 cycles, then HI shows 0 (0xBF).
- Full decode: feed 0x01, 0x23, ..., 0xEF, one per period -> every hex glyph matches the decode table in both the HI and LO positions.
